// File: rtl/ad_shuffle_sequencer_if.sv
// ---------------------------------------------------------------------------
// ad_shuffle_sequencer_if
// Stream bundle for the shuffle sequencer.
//   in_valid/in_ready/in_sof/in_data  : group-per-beat input stream
//   out_valid/out_ready/out_data      : word-index-per-beat output stream
//   out_first/out_last                : first/last beat of an output frame
//   align_err                         : sticky start-of-frame misalignment flag
// Modports:
//   master : the side driving input beats and consuming output beats
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface ad_shuffle_sequencer_if #(
  parameter int unsigned NUM_GROUPS      = 4,
  parameter int unsigned WORDS_PER_GROUP = 4,
  parameter int unsigned WORD_WIDTH      = 16
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic                                  in_sof;
  logic [WORDS_PER_GROUP*WORD_WIDTH-1:0] in_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [NUM_GROUPS*WORD_WIDTH-1:0]      out_data;
  logic                                  out_first;
  logic                                  out_last;
  logic                                  align_err;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last, align_err
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, align_err
  );
endinterface

// File: rtl/ad_shuffle_sequencer.sv
// ---------------------------------------------------------------------------
// ad_shuffle_sequencer
// Streaming perfect shuffle (corner turn) with ping-pong banks. NUM_GROUPS
// input beats (one group of WORDS_PER_GROUP words each) fill a bank; the bank
// is then drained as WORDS_PER_GROUP output beats, beat j carrying word j of
// every group.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : ad_shuffle_sequencer_if.slave (input/output streams, align_err)
// Build option:
//   AD_SHUFFLE_SEQ_REG_OUT_EN : adds a registered output stage (latency 2 clk)
// ---------------------------------------------------------------------------
module ad_shuffle_sequencer #(
  parameter int unsigned NUM_GROUPS      = 4,
  parameter int unsigned WORDS_PER_GROUP = 4,
  parameter int unsigned WORD_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  ad_shuffle_sequencer_if.slave bus
);

  localparam int unsigned GW = (NUM_GROUPS > 1)      ? $clog2(NUM_GROUPS)      : 1;
  localparam int unsigned RW = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1;
  localparam logic [GW-1:0] WR_LAST = GW'(NUM_GROUPS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(WORDS_PER_GROUP - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_e;

  bank_st_e        bank_st_q [2];
  bank_st_e        bank_st_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [GW-1:0]   wr_cnt_q,  wr_cnt_d;
  logic [RW-1:0]   rd_cnt_q,  rd_cnt_d;
  logic            align_err_q, align_err_d;

  logic [WORD_WIDTH-1:0] mem_q [2][NUM_GROUPS][WORDS_PER_GROUP];

  logic [1:0]      full;
  logic            in_ready;
  logic            wr_fire;
  logic            misalign;
  logic [GW-1:0]   wr_grp;
  logic            rd_avail;
  logic            rd_fire;
  logic            rd_first;
  logic            rd_last;
  logic [NUM_GROUPS*WORD_WIDTH-1:0] rd_data;

  // A bank counts as full from its last write until its last read.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      full[b] = (bank_st_q[b] == BANK_FULL) || (bank_st_q[b] == BANK_DRAINING);
    end
  end

  assign in_ready = resetn & ~full[wr_bank_q];
  assign wr_fire  = bus.in_valid & in_ready;
  // sof on a non-zero group restarts the current bank at group 0.
  assign misalign = bus.in_sof & (wr_cnt_q != '0);
  assign wr_grp   = misalign ? '0 : wr_cnt_q;

  assign rd_avail = full[rd_bank_q];
  assign rd_first = rd_avail & (rd_cnt_q == '0);
  assign rd_last  = rd_avail & (rd_cnt_q == RD_LAST);

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      rd_data[i*WORD_WIDTH +: WORD_WIDTH] = mem_q[rd_bank_q][i][rd_cnt_q];
    end
  end

  always_comb begin
    bank_st_d   = bank_st_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    align_err_d = align_err_q;

    // Write and read always target different banks (one requires !full,
    // the other full), so both updates can apply in the same cycle.
    if (wr_fire) begin
      if (misalign) begin
        align_err_d = 1'b1;
      end
      if (wr_grp == WR_LAST) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_cnt_d             = '0;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
        wr_cnt_d             = wr_grp + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_cnt_q == RD_LAST) begin
        bank_st_d[rd_bank_q] = BANK_EMPTY;
        rd_cnt_d             = '0;
        rd_bank_d            = ~rd_bank_q;
      end else begin
        bank_st_d[rd_bank_q] = BANK_DRAINING;
        rd_cnt_d             = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bank_st_q[b] <= BANK_EMPTY;
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      align_err_q <= 1'b0;
    end else begin
      bank_st_q   <= bank_st_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      align_err_q <= align_err_d;
    end
  end

  // Storage carries no reset; contents are only observed once a bank is full.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned k = 0; k < WORDS_PER_GROUP; k++) begin
        mem_q[wr_bank_q][wr_grp][k] <= bus.in_data[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.align_err = align_err_q;

`ifdef AD_SHUFFLE_SEQ_REG_OUT_EN
  logic                             out_valid_q, out_valid_d;
  logic                             out_first_q, out_first_d;
  logic                             out_last_q,  out_last_d;
  logic [NUM_GROUPS*WORD_WIDTH-1:0] out_data_q,  out_data_d;
  logic                             out_load;

  // The read-side handshake is the load of this stage, so a beat leaves the
  // bank when it enters the register, keeping one beat per clock.
  assign out_load = ~out_valid_q | bus.out_ready;
  assign rd_fire  = rd_avail & out_load;

  always_comb begin
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (out_load) begin
      out_valid_d = rd_avail;
      out_first_d = rd_first;
      out_last_d  = rd_last;
      out_data_d  = rd_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
`else
  assign rd_fire       = rd_avail & bus.out_ready;
  assign bus.out_valid = rd_avail;
  assign bus.out_first = rd_first;
  assign bus.out_last  = rd_last;
  assign bus.out_data  = rd_data;
`endif

endmodule

// File: tb/tb_ad_shuffle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ad_shuffle_sequencer
// Directed bench for ad_shuffle_sequencer (4 groups x 4 words x 16 bits).
// Input beats feed a transpose model that queues expected output beats; a
// monitor pops and compares on each output handshake.
// Honors AD_SHUFFLE_SEQ_REG_OUT_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_ad_shuffle_sequencer;
  localparam int unsigned NG = 4;
  localparam int unsigned WG = 4;
  localparam int unsigned WW = 16;
`ifdef AD_SHUFFLE_SEQ_REG_OUT_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;

  ad_shuffle_sequencer_if #(.NUM_GROUPS(NG), .WORDS_PER_GROUP(WG), .WORD_WIDTH(WW)) bus ();

  ad_shuffle_sequencer #(
    .NUM_GROUPS(NG),
    .WORDS_PER_GROUP(WG),
    .WORD_WIDTH(WW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NG*WW-1:0] data;
    logic             first;
    logic             last;
  } beat_t;

  beat_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_cnt = 0;
  int          gap_cnt   = 0;
  bit          watch_gaps = 1'b0;
  bit          prev_valid = 1'b0;
  logic [WW-1:0] cur [NG][WG];
  int unsigned cur_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Group g of frame tag: word k = {tag, g, k} nibbles -> tag 0 gives 16'h0g0k.
  function automatic logic [WG*WW-1:0] grp_data(input int unsigned g, input int unsigned tag);
    logic [WG*WW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < WG; k++) begin
      r[k*WW +: WW] = WW'((tag << 12) | (g << 8) | k);
    end
    return r;
  endfunction

  // Transpose model: a completed frame yields WG beats, beat j word i = group i word j.
  function automatic void model_beat(input logic [WG*WW-1:0] d, input logic sof);
    beat_t b;
    if (sof && cur_cnt != 0) cur_cnt = 0;
    for (int unsigned k = 0; k < WG; k++) cur[cur_cnt][k] = d[k*WW +: WW];
    cur_cnt++;
    if (cur_cnt == NG) begin
      for (int unsigned j = 0; j < WG; j++) begin
        b.data = '0;
        for (int unsigned i = 0; i < NG; i++) b.data[i*WW +: WW] = cur[i][j];
        b.first = (j == 0);
        b.last  = (j == WG - 1);
        sb_q.push_back(b);
      end
      cur_cnt = 0;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send_beat(input logic [WG*WW-1:0] d, input logic sof);
    bit ok;
    bit rdy;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (!rdy) stall_cnt++;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    if (ok) model_beat(d, sof);
    else check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_frame(input int unsigned tag);
    for (int unsigned g = 0; g < NG; g++) send_beat(grp_data(g, tag), (g == 0));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100 && sb_q.size() != 0; c++) @(negedge clk);
    check("drain_queue_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_beat", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("out_first_last", 64'({bus.out_first, bus.out_last}), 64'({e.first, e.last}));
        end
      end
      if (watch_gaps && resetn && !bus.out_valid && prev_valid && sb_q.size() != 0) gap_cnt++;
      prev_valid = resetn && bus.out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_flags", 64'({bus.out_valid, bus.out_first, bus.out_last}), 64'(0));
    check("rst_align_err", 64'(bus.align_err), 64'(0));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Single frame, word w of group g = 16'h0g0w
    bus.out_ready = 1'b1;
    send_frame(0);
    idle();
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_first) begin
        lat = c;
        check("frame0_beat0_direct", 64'(bus.out_data), 64'h0300_0200_0100_0000);
      end
    end
    check("first_latency", 64'(lat), 64'(LAT));
    wait_drain();

    // Back-to-back frames
    stall_cnt  = 0;
    gap_cnt    = 0;
    watch_gaps = 1'b1;
    for (int unsigned f = 1; f <= 8; f++) send_frame(f);
    idle();
    wait_drain();
    watch_gaps = 1'b0;
    check("b2b_in_ready_stalls", 64'(stall_cnt), 64'(0));
    check("b2b_output_gaps", 64'(gap_cnt), 64'(0));

    // Full backpressure: two frames fill both banks, third waits
    bus.out_ready = 1'b0;
    stall_cnt = 0;
    send_frame(9);
    send_frame(10);
    check("bp_first8_no_stall", 64'(stall_cnt), 64'(0));
    fork
      send_frame(11);
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        check("bp_out_valid", 64'(bus.out_valid), 64'(1));
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("bp_out_data_held", 64'(bus.out_data), 64'(sb_q[0].data));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle();
    wait_drain();
    check("bp_third_frame_stalled", 64'(stall_cnt != 0), 64'(1));

    // Misalignment: two beats, then sof restarts the frame
    send_beat(grp_data(0, 12), 1'b1);
    send_beat(grp_data(1, 12), 1'b0);
    @(negedge clk);
    check("align_err_before", 64'(bus.align_err), 64'(0));
    @(posedge clk);
    #1;
    send_beat(grp_data(0, 13), 1'b1);
    send_beat(grp_data(1, 13), 1'b0);
    send_beat(grp_data(2, 13), 1'b0);
    send_beat(grp_data(3, 13), 1'b0);
    idle();
    wait_drain();
    check("align_err_set", 64'(bus.align_err), 64'(1));

    // Mid-drain reset
    send_frame(14);
    idle();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    sb_q.delete();
    cur_cnt = 0;
    #1;
    check("midrst_out_flags", 64'({bus.out_valid, bus.out_first, bus.out_last}), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    check("midrst_align_err", 64'(bus.align_err), 64'(0));
    @(posedge clk);
    #1 resetn = 1'b1;
    send_frame(15);
    idle();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ad_shuffle_sequencer.md
Name: ad_shuffle_sequencer

Overview:
- Streaming, time-domain perfect shuffle (corner turn) for the JESD204 link transport path.
- Input side: accepts NUM_GROUPS beats, one group per beat, each holding WORDS_PER_GROUP words.
- Output side: emits WORDS_PER_GROUP beats; output beat j carries word j of every group.
- Double-buffered (ping-pong banks) so sustained full throughput is possible. Valid/ready handshake on both sides, plus start-of-frame alignment.

Parameters:
- NUM_GROUPS, 4, groups per frame = input beats per bank.
- WORDS_PER_GROUP, 4, words per input beat = output beats per bank.
- WORD_WIDTH, 16, bits per word.

Ports:
- clk  input  1  sole clock; all logic rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_sof  input  1  marks the beat as group 0 of a frame; sampled only on handshake.
- in_data  input  WORDS_PER_GROUP*WORD_WIDTH  word k at bits [k*WORD_WIDTH +: WORD_WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  NUM_GROUPS*WORD_WIDTH  word i = group i's word j, where j is the current output beat.
- out_first  output  1  high with beat j=0.
- out_last  output  1  high with beat j=WORDS_PER_GROUP-1.
- align_err  output  1  sticky; in_sof arrived mid-bank.

Behaviour:
- Storage:
  - Two banks, each NUM_GROUPS x WORDS_PER_GROUP words.
  - Per-bank full flag.
  - wr_bank and wr_cnt (0..NUM_GROUPS-1); rd_bank and rd_cnt (0..WORDS_PER_GROUP-1).
- Bank state per bank: EMPTY -> FILLING (first write) -> FULL (last group written) -> DRAINING (first read) -> EMPTY (last beat read).
- Write side:
  - in_ready = resetn & !full[wr_bank], combinational.
  - On handshake: store in_data into group wr_cnt of wr_bank, then wr_cnt++.
  - At wr_cnt=NUM_GROUPS-1: set full[wr_bank], wr_cnt<=0, toggle wr_bank.
- Alignment:
  - Handshake with in_sof=1 and wr_cnt!=0: discard the partial bank, write this beat as group 0 (wr_cnt<=1), and set align_err.
  - in_sof=0 with wr_cnt=0: accepted normally; no error.
  - align_err clears only on reset.
  - Special case NUM_GROUPS=1: every beat completes a bank.
- Read side:
  - out_valid = full[rd_bank].
  - out_data word i = bank[rd_bank].group[i].word[rd_cnt]; combinational mux from storage.
  - On out_valid & out_ready: rd_cnt++.
  - At rd_cnt=WORDS_PER_GROUP-1: clear full[rd_bank], rd_cnt<=0, toggle rd_bank.
  - out_first = out_valid & (rd_cnt==0); out_last = out_valid & (rd_cnt==WORDS_PER_GROUP-1).
- Latency: first output beat is valid the cycle after the handshake that completes a bank (1 clk).
- Throughput: with out_ready=1 and NUM_GROUPS==WORDS_PER_GROUP, in_ready never drops.
- Simultaneous events:
  - Write into one bank and read-complete of the other bank in the same cycle are independent.
  - A bank freed in cycle N is writable in cycle N+1, not N.
- Backpressure: both banks full -> in_ready=0. out_data is held stable while out_valid & !out_ready.
- Reset, including mid-operation:
  - Counters, banks pointers and full flags go to 0; align_err=0.
  - out_valid=0, out_first=0, out_last=0, in_ready=0 while resetn low.
  - Storage contents need no reset.
  - Partial frames in flight are lost.

Optional Feature:
- Macro: AD_SHUFFLE_SEQ_REG_OUT_EN.
- Defined:
  - Adds one output register stage for out_valid/out_data/out_first/out_last.
  - The stage loads when !out_valid_q | out_ready; the read handshake occurs on that load.
  - out_valid_q resets to 0.
  - Latency 2 clk; throughput unchanged (no bubbles with out_ready=1).
- Undefined: combinational outputs as above; latency 1 clk.

Test Plan:
- Single frame, defaults (4/4/16).
  - Stimulus: beat g carries word w = 16'h0g0w, in_sof on g=0, out_ready=1.
  - Required: 4 out beats; beat j word i = 16'h0i0j; out_first on j=0, out_last on j=3; first out_valid 1 clk after 4th input handshake.
- Back-to-back frames.
  - Stimulus: 8 frames streamed continuously, out_ready=1.
  - Required: in_ready constantly 1; 32 output beats in order; no gaps after the initial latency.
- Full backpressure.
  - Stimulus: out_ready=0, send 3 frames.
  - Required: in_ready drops after beat 8; out_data stable. Release out_ready: frames 1 and 2 drain correctly, frame 3 then accepted.
- Misalignment.
  - Stimulus: 2 beats, then a beat with in_sof=1, then 3 more.
  - Required: align_err=1; output beats reflect only the last 4 beats as groups 0..3.
- Mid-operation reset.
  - Stimulus: assert resetn=0 for 1 clk mid-drain.
  - Required: out_valid=0 immediately (asynchronously); align_err=0; next full frame output correctly.
- Repeat the first two scenarios with AD_SHUFFLE_SEQ_REG_OUT_EN defined.
  - Required: same data order, latency 2 clk, no throughput loss.
